// File: rtl/mem_map_pkg.sv
// Address map, state encoding and latched-request type shared by the
// memory responder and its RAM.
package mem_map_pkg;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] IO_OUT_ADDR      = 32'h1001_0024;
  localparam logic [31:0] IO_IN_ADDR       = 32'h1001_0028;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, combinational read.
// Contents are intentionally not reset.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW          = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: RAM window plus two MMIO registers,
// one outstanding request, one-cycle registered response.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  req_t          req_q, cur;
  logic          accept, enter_resp;
  logic [31:0]   offset;
  logic          ram_hit, io_out_hit, io_in_hit;
  logic          ram_we, gpio_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_rdata, rdata_nxt;
  logic          err_nxt;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state == RESP);

  // In IDLE the live request is decoded so a zero-wait access can
  // complete on its accept edge; afterwards only the latched copy counts.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur.we    = req_we;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end
  end

  always_comb begin
    offset     = cur.addr - MEM_BASE;
    ram_hit    = is_aligned(cur.addr) && (cur.addr >= MEM_BASE) &&
                 ({1'b0, offset} < RAM_BYTES);
    io_out_hit = (cur.addr == IO_OUT_ADDR);
    io_in_hit  = (cur.addr == IO_IN_ADDR);
    ram_idx    = offset[AW+1:2];
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata_nxt = 32'h0;
    err_nxt   = 1'b0;
    gpio_we   = 1'b0;
    if (ram_hit) begin
      if (!cur.we) rdata_nxt = ram_rdata;
    end else if (io_out_hit) begin
      if (cur.we) gpio_we = 1'b1;
      else        rdata_nxt = {24'h0, gpio_out};
    end else if (io_in_hit) begin
      if (!cur.we) rdata_nxt = {24'h0, gpio_in};
    end else begin
      err_nxt = 1'b1;
    end
  end

  // Reset gates the commit so an aborted write never reaches the RAM.
  assign ram_we = enter_resp & cur.we & ram_hit & ~rst;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_idx),
    .wdata(cur.wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_q      <= '0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      gpio_out   <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req_q <= cur;
      if (enter_resp) begin
        resp_rdata <= rdata_nxt;
        resp_err   <= err_nxt;
        if (gpio_we) gpio_out <= cur.wdata[7:0];
      end else if (state == RESP) begin
        resp_rdata <= 32'h0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a two-wait-state
// instance, plus reset-abort, ignored-request and zero-wait sequences.
module tb_mem_responder;
  import mem_map_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  gpio_in, gpio_out;

  logic        req_valid0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;
  logic [7:0]  gpio_out0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .gpio_in(gpio_in), .gpio_out(gpio_out0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  gin;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on the WAIT_CYCLES=2 instance; lat counts cycles
  // from the accept cycle to resp_valid (99 if it never comes).
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wd;
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("w0_resp_next_cycle", {31'h0, resp_valid0}, 32'h1);
    chk("w0_write_err", {31'h0, resp_err0}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;
    logic [31:0] exp_d;

    vecs[0]  = '{1'b1, 32'h0040_0008, 32'hDEAD_BEEF, 8'h00, 32'h0,         1'b0, 8'h00};
    vecs[1]  = '{1'b0, 32'h0040_0008, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 32'h0040_0002, 32'h0,         8'h00, 32'h0,         1'b1, 8'h00};
    vecs[3]  = '{1'b0, 32'h2000_0000, 32'h0,         8'h00, 32'h0,         1'b1, 8'h00};
    vecs[4]  = '{1'b1, 32'h0040_0002, 32'h1111_1111, 8'h00, 32'h0,         1'b1, 8'h00};
    vecs[5]  = '{1'b0, 32'h0040_0008, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 32'h0040_00FC, 32'hCAFE_F00D, 8'h00, 32'h0,         1'b0, 8'h00};
    vecs[7]  = '{1'b0, 32'h0040_00FC, 32'h0,         8'h00, 32'hCAFE_F00D, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 32'h0040_0100, 32'h2222_2222, 8'h00, 32'h0,         1'b1, 8'h00};
    vecs[9]  = '{1'b0, 32'h003F_FFFC, 32'h0,         8'h00, 32'h0,         1'b1, 8'h00};
    vecs[10] = '{1'b1, IO_OUT_ADDR,   32'h0000_00A5, 8'h00, 32'h0,         1'b0, 8'hA5};
    vecs[11] = '{1'b0, IO_OUT_ADDR,   32'h0,         8'h00, 32'h0000_00A5, 1'b0, 8'hA5};
    vecs[12] = '{1'b0, IO_IN_ADDR,    32'h0,         8'h3C, 32'h0000_003C, 1'b0, 8'hA5};
    vecs[13] = '{1'b1, IO_IN_ADDR,    32'hFFFF_FFFF, 8'h3C, 32'h0,         1'b0, 8'hA5};
    vecs[14] = '{1'b0, IO_IN_ADDR,    32'h0,         8'hC3, 32'h0000_00C3, 1'b0, 8'hA5};
    vecs[15] = '{1'b1, 32'h1001_0025, 32'h0000_005A, 8'h00, 32'h0,         1'b1, 8'hA5};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    gpio_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_rdata", resp_rdata, 32'h0);
    chk("reset_err", {31'h0, resp_err}, 32'h0);
    chk("reset_gpio_out", {24'h0, gpio_out}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      gpio_in = vecs[i].gin;
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd3);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_gpio_out", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_gpio});
      @(negedge clk);
      chk($sformatf("v%0d_resp_one_cycle", i), {31'h0, resp_valid}, 32'h0);
      chk($sformatf("v%0d_rdata_cleared", i), resp_rdata, 32'h0);
      chk($sformatf("v%0d_err_cleared", i), {31'h0, resp_err}, 32'h0);
    end

    // Reset during WAIT aborts a pending RAM write.
    txn(1'b1, 32'h0040_0000, 32'h0BAD_F00D, rd, er, lat);
    chk("prior_write_latency", lat, 32'd3);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0040_0000; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_resp", seen, 32'd0);
    chk("abort_gpio_out", {24'h0, gpio_out}, 32'h0);
    txn(1'b0, 32'h0040_0000, 32'h0, rd, er, lat);
    chk("abort_read_prior", rd, 32'h0BAD_F00D);
    chk("abort_read_latency", lat, 32'd3);

    // A request presented during WAIT is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0040_0008; req_wdata = 32'h0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h0040_00FC; req_wdata = 32'h0;
    chk("wait_not_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_no_early_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    chk("ignored_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("ignored_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("ignored_err", {31'h0, resp_err}, 32'h0);
    txn(1'b0, 32'h0040_00FC, 32'h0, rd, er, lat);
    chk("ignored_no_write", rd, 32'hCAFE_F00D);

    // Zero-wait instance: back-to-back reads with req_valid held high.
    txn0(1'b1, 32'h0040_0004, 32'h55AA_55AA);
    txn0(1'b1, 32'h0040_0008, 32'h0102_0304);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h0040_0004;
    exp_d = 32'h55AA_55AA;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        chk($sformatf("b2b%0d_ready", i), {31'h0, req_ready0}, 32'h1);
        chk($sformatf("b2b%0d_idle_no_resp", i), {31'h0, resp_valid0}, 32'h0);
      end else begin
        chk($sformatf("b2b%0d_busy", i), {31'h0, req_ready0}, 32'h0);
        chk($sformatf("b2b%0d_resp", i), {31'h0, resp_valid0}, 32'h1);
        chk($sformatf("b2b%0d_rdata", i), resp_rdata0, exp_d);
        if (req_addr0 == 32'h0040_0004) begin
          req_addr0 = 32'h0040_0008; exp_d = 32'h0102_0304;
        end else begin
          req_addr0 = 32'h0040_0004; exp_d = 32'h55AA_55AA;
        end
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    chk("w0_gpio_out_untouched", {24'h0, gpio_out0}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64; number of 32-bit words in the RAM window.
REQ-002 Parameter WAIT_CYCLES, default 2; wait states inserted between request accept and response (legal range 0..15).
REQ-003 Parameter MEM_BASE, default 32'h0040_0000; byte base address of the RAM window.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port req_valid  input  1  initiator (multicycle control/datapath) presents a memory request.
REQ-007 Port req_ready  output  1  responder can accept a request this cycle.
REQ-008 Port req_we  input  1  1 = write, 0 = read (instruction fetch or load).
REQ-009 Port req_addr  input  32  byte address.
REQ-010 Port req_wdata  input  32  store data.
REQ-011 Port resp_valid  output  1  one-cycle pulse: response data/status valid.
REQ-012 Port resp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 Port resp_err  output  1  request was misaligned or unmapped.
REQ-014 Port gpio_in  input  8  external inputs, readable at IO_IN_ADDR.
REQ-015 Port gpio_out  output  8  MMIO output register at IO_OUT_ADDR.

Function
REQ-016 States IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept = req_valid & req_ready; on accept, addr/we/wdata SHALL be latched and the wait counter loaded with WAIT_CYCLES.
REQ-018 IDLE->WAIT on accept when WAIT_CYCLES>0; IDLE->RESP on accept when WAIT_CYCLES==0; otherwise stay in IDLE.
REQ-019 WAIT decrements the counter each cycle; WAIT->RESP when the counter reaches 1.
REQ-020 RESP asserts resp_valid for exactly one cycle, then returns to IDLE unconditionally (no backpressure).
REQ-021 Latency: accept at cycle T gives resp_valid at cycle T+WAIT_CYCLES+1; next accept no earlier than T+WAIT_CYCLES+2.
REQ-022 RAM hit: addr[1:0]==0 and MEM_BASE <= addr < MEM_BASE+4*DEPTH_WORDS; word index = (addr-MEM_BASE)>>2.
REQ-023 MMIO: IO_OUT_ADDR write loads gpio_out from wdata[7:0]; a read returns {24'b0,gpio_out}. IO_IN_ADDR read returns {24'b0,gpio_in} sampled in the RESP-entry cycle; a write to it is ignored without error.
REQ-024 Any other address, or addr[1:0]!=0, SHALL give resp_err=1 and resp_rdata=0 with no state change.
REQ-025 Writes SHALL commit on the clock edge entering RESP; a read of that word in the next transaction returns the new value.
REQ-026 resp_rdata and resp_err SHALL be registered and held stable during the RESP cycle; both SHALL be 0 outside RESP.
REQ-027 req_valid while not in IDLE SHALL be ignored; the latched request SHALL NOT change.

Reset
REQ-028 rst=1 at a clock edge forces IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, gpio_out 8'h00, req_ready 1 from the following cycle.
REQ-029 Reset in WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT commit and no response SHALL be issued.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package mem_map_pkg SHALL hold MEM_BASE default, IO_OUT_ADDR=32'h1001_0024, IO_IN_ADDR=32'h1001_0028, and the state encoding IDLE/WAIT/RESP.
REQ-032 RAM SHALL be a sub-module mem_array: single-port, synchronous write, DEPTH_WORDS x 32.

Verification
REQ-033 Write 32'hDEADBEEF to 32'h0040_0008, then read it back (WAIT_CYCLES=2) -> resp_valid at accept+3 both times; read returns 32'hDEADBEEF, resp_err=0.
REQ-034 Read 32'h0040_0002 and 32'h2000_0000 -> resp_err=1, resp_rdata=0; RAM unchanged.
REQ-035 Write 32'h0000_00A5 to IO_OUT_ADDR -> gpio_out=8'hA5 after the RESP edge; gpio_in=8'h3C, read IO_IN_ADDR -> resp_rdata=32'h0000_003C.
REQ-036 WAIT_CYCLES=0, back-to-back reads with req_valid held high -> accepts every 2nd cycle, resp_valid the cycle after each accept.
REQ-037 Write 32'h1234_5678 to 32'h0040_0000, assert rst during WAIT -> no resp_valid, gpio_out=0, subsequent read returns the prior contents.
REQ-038 Pulse req_valid with a different address during WAIT -> ignored; response reflects the original request only.
